// File: rtl/serial_subtractor_16bit.sv
// Bit-serial 16-bit subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional zero-result flag output is enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_subtractor_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        borrow_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] diff,
  output logic        underflow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic        zero
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, next_state;
  logic [15:0] a_r, b_r, sh;
  logic        br;
  logic [3:0]  cnt;
  logic        load;
  logic        d_bit, nxt_br;

  // Operands are captured from IDLE or from DONE (back-to-back); start is ignored in CALC.
  assign load   = start && (state == IDLE || state == DONE);
  assign d_bit  = a_r[0] ^ b_r[0] ^ br;
  assign nxt_br = (~a_r[0] & b_r[0]) | (~(a_r[0] ^ b_r[0]) & br);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == 4'd15) next_state = DONE;
      DONE:    next_state = start ? CALC : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= 16'h0000;
      underflow <= 1'b0;
      a_r       <= 16'h0000;
      b_r       <= 16'h0000;
      sh        <= 16'h0000;
      br        <= 1'b0;
      cnt       <= 4'd0;
    end else begin
      state <= next_state;
      busy  <= (next_state == CALC);
      done  <= (state == DONE);
      // Result is published from the completed shift register while in DONE,
      // before any back-to-back load clears it on this same edge.
      if (state == DONE) begin
        diff      <= sh;
        underflow <= br;
      end
      if (load) begin
        a_r <= a;
        b_r <= b;
        br  <= borrow_in;
        sh  <= 16'h0000;
        cnt <= 4'd0;
      end else if (state == CALC) begin
        a_r <= {1'b0, a_r[15:1]};
        b_r <= {1'b0, b_r[15:1]};
        sh  <= {d_bit, sh[15:1]};
        br  <= nxt_br;
        cnt <= cnt + 4'd1;
      end
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst)                zero <= 1'b0;
    else if (state == DONE) zero <= (sh == 16'h0000);
  end
`endif

endmodule
